// File: rtl/bitlogic_pkg.sv
// Shared types for the bitlogic lane pipeline: operating modes, the per-lane
// stage-1 payload and the lane evaluation function.
package bitlogic_pkg;

  typedef enum logic [1:0] {
    MODE_COMPLETE = 2'd0,
    MODE_PARTIAL  = 2'd1,
    MODE_BCAST    = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // One lane's worth of stage-1 state; the full payload is an array of these.
  typedef struct packed {
    logic t;
    logic a;
    logic dsel;
    logic mask;
  } lane_t;

  localparam int LANE_BITS = $bits(lane_t);

  function automatic logic lane_eval(input lane_t l);
    return (l.a | (l.t ^ l.dsel)) & ~l.mask;
  endfunction

endpackage

// File: rtl/bitlogic_lane_stage.sv
// Generic WIDTH-bit valid/ready pipeline register. When adv is high the stage
// takes in_vld, and captures d only when that incoming beat is valid.
module bitlogic_lane_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] d,
  output logic             vld,
  output logic [WIDTH-1:0] q
);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; the payload is reset too so out_data starts at a known 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (adv) begin
      vld <= in_vld;
      if (in_vld) q <= d;
    end
  end

endmodule

// File: rtl/bitlogic_lane_pipe.sv
// Two-stage pipelined per-bit logic unit: o[i] = a[i] | ((b[i] & ~c[i]) ^ dsel[i]),
// with partial/broadcast modes. Define BITLOGIC_PARITY_EN to add out_parity.
module bitlogic_lane_pipe
  import bitlogic_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] ZERO_MASK = WIDTH'(8'h08),
  parameter int               BCAST_IDX = 4,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
`ifdef BITLOGIC_PARITY_EN
  output logic             out_parity,
`endif
  output logic             err_mode
);

  localparam int S1_W = WIDTH * LANE_BITS + 1;
`ifdef BITLOGIC_PARITY_EN
  localparam int S2_W = WIDTH + 1;
`else
  localparam int S2_W = WIDTH;
`endif

  typedef struct packed {
    lane_t [WIDTH-1:0] lanes;
    logic              mode3;
  } s1_payload_t;

  mode_e            mode;
  s1_payload_t      s1_d;
  s1_payload_t      s1_q;
  logic             s1_valid;
  logic             s2_valid;
  logic             s1_load;
  logic             s2_load;
  logic             s2_adv;
  logic [WIDTH-1:0] result;
  logic [S2_W-1:0]  s2_d;
  logic [S2_W-1:0]  s2_q;

  assign mode = mode_e'(in_mode);

  // Stage 2 empties on out_ready even with no new beat behind it, so its
  // valid advances on s2_adv while its data only loads on s2_load.
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = !s1_valid || !s2_valid || out_ready;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    s1_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s1_d.lanes[i].t    = in_b[i] & ~in_c[i];
      s1_d.lanes[i].a    = in_a[i];
      s1_d.lanes[i].dsel = (mode == MODE_BCAST) ? in_d[BCAST_IDX] : in_d[i];
      s1_d.lanes[i].mask = (mode == MODE_PARTIAL) && ZERO_MASK[i];
    end
    s1_d.mode3 = (mode == MODE_RSVD);
  end

  bitlogic_lane_stage #(.WIDTH(S1_W)) u_stage1 (
    .clk    (clk),
    .rst    (rst),
    .adv    (s1_load),
    .in_vld (in_valid),
    .d      (s1_d),
    .vld    (s1_valid),
    .q      (s1_q)
  );

  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = lane_eval(s1_q.lanes[i]);
    end
  end

`ifdef BITLOGIC_PARITY_EN
  assign s2_d       = {^result, result};
  assign out_parity = s2_q[WIDTH];
`else
  assign s2_d = result;
`endif

  bitlogic_lane_stage #(.WIDTH(S2_W)) u_stage2 (
    .clk    (clk),
    .rst    (rst),
    .adv    (s2_adv),
    .in_vld (s1_valid),
    .d      (s2_d),
    .vld    (s2_valid),
    .q      (s2_q)
  );

  assign out_valid = s2_valid;
  assign out_data  = s2_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
      err_mode  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_count <= out_count + 1'b1;
      if (s2_load && s1_q.mode3)  err_mode  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bitlogic_lane_pipe.sv
// Directed bench for bitlogic_lane_pipe with a queue scoreboard; a second
// instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_bitlogic_lane_pipe;

  localparam int         WIDTH = 8;
  localparam logic [7:0] ZMASK = 8'h08;
  localparam int         BIDX  = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [7:0]  in_a, in_b, in_c, in_d;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_count;
  logic        err_mode;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [7:0]  w_out_data;
  logic [1:0]  w_out_count;
  logic        w_err_mode;
`ifdef BITLOGIC_PARITY_EN
  logic        out_parity;
  logic        w_out_parity;
`endif

  int          n_compared   = 0;
  int          n_mismatched = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt_w;
  logic [7:0]  last_data;
  logic        stalled;

  bitlogic_lane_pipe #(.WIDTH(WIDTH), .ZERO_MASK(ZMASK), .BCAST_IDX(BIDX), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
`ifdef BITLOGIC_PARITY_EN
    .out_parity(out_parity),
`endif
    .err_mode(err_mode)
  );

  bitlogic_lane_pipe #(.WIDTH(WIDTH), .ZERO_MASK(ZMASK), .BCAST_IDX(BIDX), .CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_data(w_out_data), .out_count(w_out_count),
`ifdef BITLOGIC_PARITY_EN
    .out_parity(w_out_parity),
`endif
    .err_mode(w_err_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] a, b, c, d, input logic [1:0] m);
    logic [7:0] dsel;
    logic [7:0] r;
    dsel = (m == 2'd2) ? {8{d[BIDX]}} : d;
    r    = a | ((b & ~c) ^ dsel);
    if (m == 2'd1) r = r & ~ZMASK;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called once per negedge: scoreboard pop on output fire plus stall stability.
  task automatic observe();
    logic [7:0] e;
    if (!rst) begin
      if (stalled) check("stall_stable", out_data, last_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          check("wrap_out_data", w_out_data, e);
`ifdef BITLOGIC_PARITY_EN
          check("out_parity", out_parity, ^e);
`endif
          check("out_count", out_count, exp_cnt);
          check("wrap_out_count", w_out_count, exp_cnt_w);
          exp_cnt   = exp_cnt + 1'b1;
          exp_cnt_w = exp_cnt_w + 1'b1;
        end
      end
      stalled   = out_valid && !out_ready;
      last_data = out_data;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    observe();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    settle();
    advance();
  endtask

  task automatic send(input logic [7:0] a, b, c, d, input logic [1:0] m);
    int waited = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c; in_d = d; in_mode = m;
    do begin
      settle();
      if (in_ready) break;
      advance();
      waited++;
    end while (waited < 64);
    check("accept", in_ready, 1);
    if (in_ready) exp_q.push_back(model(a, b, c, d, m));
    advance();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 32) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_cnt   = '0;
    exp_cnt_w = '0;
    stalled   = 1'b0;
    advance();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb, rc, rd;
    logic [1:0] rm;
    rst = 1'b1; in_valid = 1'b0; in_mode = '0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    exp_cnt = '0; exp_cnt_w = '0; stalled = 1'b0; last_data = '0;
    advance();
    advance();
    do_reset();

    // Reset state
    settle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_err_mode", err_mode, 0);
    check("rst_in_ready", in_ready, 1);
    advance();

    // Complete mode with latency: out_valid rises two cycles after the fire
    send(8'h00, 8'hFF, 8'h00, 8'h10, 2'd0);
    settle();
    check("lat_n1_valid", out_valid, 0);
    advance();
    settle();
    check("lat_n2_valid", out_valid, 1);
    advance();
    settle();
    check("complete_count", out_count, 1);
    advance();

    // Partial and broadcast, back to back
    send(8'h00, 8'hFF, 8'h00, 8'h00, 2'd1);
    send(8'h00, 8'hFF, 8'h00, 8'h00, 2'd0);
    send(8'h00, 8'hFF, 8'h00, 8'h10, 2'd2);
    send(8'h00, 8'hFF, 8'h00, 8'hEF, 2'd2);
    drain();

    // Backpressure: 5 random beats against a 4-cycle stall
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
    end
    ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
    rm = 2'($urandom_range(0, 2));
    in_valid = 1'b1;
    in_a = ra; in_b = rb; in_c = rc; in_d = rd; in_mode = rm;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      advance();
    end
    out_ready = 1'b1;
    send(ra, rb, rc, rd, rm);
    for (int i = 0; i < 2; i++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 2)));
    end
    drain();
    settle();
    check("bp_out_count", out_count, 5);
    advance();

    // Reserved mode sets a sticky error
    send(8'h00, 8'hFF, 8'h00, 8'h10, 2'd3);
    drain();
    settle();
    check("rsvd_err_set", err_mode, 1);
    advance();
    send(8'h00, 8'hFF, 8'h00, 8'h00, 2'd0);
    drain();
    settle();
    check("rsvd_err_sticky", err_mode, 1);
    advance();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(8'h12, 8'h34, 8'h56, 8'h78, 2'd0);
    send(8'h9A, 8'hBC, 8'hDE, 8'hF0, 2'd1);
    do_reset();
    out_ready = 1'b1;
    settle();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err_mode", err_mode, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    advance();
    cycle();
    cycle();
    settle();
    check("mid_rst_no_ghost", out_valid, 0);
    advance();

    // Counter wrap on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) send(8'h00, 8'hFF, 8'h00, 8'h10, 2'd0);
    drain();
    settle();
    check("wrap_final_count", w_out_count, 1);
    check("wide_final_count", out_count, 5);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
